// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port memory between instruction fetch (I)
//                and load/store (D); D has bounded priority, read data is
//                routed back in issue order via a fixed-latency tag pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int BUS_WIDTH    = 32,
    parameter int RD_LAT       = 2,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [BUS_WIDTH-1:0] i_addr,
    input  logic                 i_flush,
    output logic                 i_rsp_valid,
    output logic [BUS_WIDTH-1:0] i_rsp_data,
    input  logic                 d_valid,
    output logic                 d_ready,
    input  logic                 d_wr,
    input  logic [BUS_WIDTH-1:0] d_addr,
    input  logic [BUS_WIDTH-1:0] d_wdata,
    output logic                 d_rsp_valid,
    output logic [BUS_WIDTH-1:0] d_rsp_data,
    input  logic                 mem_ready,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [BUS_WIDTH-1:0] mem_addr,
    output logic [BUS_WIDTH-1:0] mem_wdata,
    input  logic [BUS_WIDTH-1:0] mem_rdata
);

    localparam logic [3:0] c_max_streak = 4'(MAX_D_STREAK);

    logic [3:0]        r_streak_cnt;
    logic [RD_LAT-1:0] r_tag_vld;
    logic [RD_LAT-1:0] r_tag_id;    // 0 = I, 1 = D

    logic w_grant_d;
    logic w_grant_i;
    logic w_rd_grant;
    logic w_last_vld;
    logic w_last_id;

    always_comb begin
        w_grant_d  = !reset && mem_ready && d_valid &&
                     (!i_valid || (r_streak_cnt < c_max_streak));
        w_grant_i  = !reset && mem_ready && i_valid && !w_grant_d;
        w_rd_grant = w_grant_i || (w_grant_d && !d_wr);
        w_last_vld = r_tag_vld[RD_LAT-1];
        w_last_id  = r_tag_id[RD_LAT-1];
    end

    assign i_ready   = w_grant_i;
    assign d_ready   = w_grant_d;
    assign mem_en    = w_grant_i || w_grant_d;
    assign mem_we    = w_grant_d && d_wr;
    assign mem_addr  = w_grant_d ? d_addr : (w_grant_i ? i_addr : '0);
    assign mem_wdata = w_grant_d ? d_wdata : '0;

    // A flush also kills the fetch response emerging this very cycle
    assign i_rsp_valid = !reset && w_last_vld && !w_last_id && !i_flush;
    assign d_rsp_valid = !reset && w_last_vld && w_last_id;
    assign i_rsp_data  = i_rsp_valid ? mem_rdata : '0;
    assign d_rsp_data  = d_rsp_valid ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag_vld <= '0;
            r_tag_id  <= '0;
        end else begin
            r_tag_vld[0] <= w_rd_grant && !(i_flush && w_grant_i);
            r_tag_id[0]  <= w_grant_d;
            for (int k = 1; k < RD_LAT; k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1] && !(i_flush && !r_tag_id[k-1]);
                r_tag_id[k]  <= r_tag_id[k-1];
            end
        end
    end

    // Streak only counts D wins over a waiting fetch; stalls freeze it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_streak_cnt <= 4'd0;
        end else if (mem_ready) begin
            if (w_grant_i || !i_valid) begin
                r_streak_cnt <= 4'd0;
            end else if (w_grant_d && (r_streak_cnt < c_max_streak)) begin
                r_streak_cnt <= r_streak_cnt + 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed scoreboard bench for mem_port_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int BW     = 32;
    localparam int RD_LAT = 2;
    localparam int MAXS   = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_valid, i_ready, i_flush, i_rsp_valid;
    logic [BW-1:0] i_addr, i_rsp_data;
    logic          d_valid, d_ready, d_wr, d_rsp_valid;
    logic [BW-1:0] d_addr, d_wdata, d_rsp_data;
    logic          mem_ready, mem_en, mem_we;
    logic [BW-1:0] mem_addr, mem_wdata, mem_rdata;

    typedef struct {
        logic [BW-1:0] data;
        int            due;
    } exp_t;

    exp_t qi[$];
    exp_t qd[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;

    logic [BW-1:0] mem_arr [256];
    logic [BW-1:0] rd_pipe [RD_LAT];

    mem_port_arbiter #(.BUS_WIDTH(BW), .RD_LAT(RD_LAT), .MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_flush(i_flush),
        .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_wr(d_wr), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .mem_ready(mem_ready), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic logic [BW-1:0] init_word(input int k);
        case (k)
            'h40:    return 32'h0000_AAAA;   // 0x100
            'h41:    return 32'h0000_1104;   // 0x104
            'h42:    return 32'h0000_1108;   // 0x108
            'h80:    return 32'h0000_BBBB;   // 0x200
            default: return 32'h0;
        endcase
    endfunction

    // Memory macro model: word array, fixed read latency
    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 256; k++) mem_arr[k] <= init_word(k);
        end else if (mem_en && mem_we) begin
            mem_arr[mem_addr[9:2]] <= mem_wdata;
        end
        rd_pipe[0] <= (mem_en && !mem_we) ? mem_arr[mem_addr[9:2]] : 32'h0;
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    // Response monitor
    always @(negedge clk) begin
        exp_t e;
        if (qi.size() > 0 && qi[0].due < cyc_n) begin
            e = qi.pop_front();
            checks++; errors++;
            $display("FAIL i_rsp missing: no response, expected data %h at cycle %0d", e.data, e.due);
        end
        if (qd.size() > 0 && qd[0].due < cyc_n) begin
            e = qd.pop_front();
            checks++; errors++;
            $display("FAIL d_rsp missing: no response, expected data %h at cycle %0d", e.data, e.due);
        end
        checks++;
        if (i_rsp_valid) begin
            if (qi.size() == 0) begin
                errors++;
                $display("FAIL i_rsp unexpected: got data %h at cycle %0d, expected none", i_rsp_data, cyc_n);
            end else begin
                e = qi.pop_front();
                if (i_rsp_data !== e.data || cyc_n != e.due) begin
                    errors++;
                    $display("FAIL i_rsp: got %h at cycle %0d, expected %h at cycle %0d", i_rsp_data, cyc_n, e.data, e.due);
                end
            end
        end else if (i_rsp_data !== 32'h0) begin
            errors++;
            $display("FAIL i_rsp_data idle: got %h, expected 0", i_rsp_data);
        end
        checks++;
        if (d_rsp_valid) begin
            if (qd.size() == 0) begin
                errors++;
                $display("FAIL d_rsp unexpected: got data %h at cycle %0d, expected none", d_rsp_data, cyc_n);
            end else begin
                e = qd.pop_front();
                if (d_rsp_data !== e.data || cyc_n != e.due) begin
                    errors++;
                    $display("FAIL d_rsp: got %h at cycle %0d, expected %h at cycle %0d", d_rsp_data, cyc_n, e.data, e.due);
                end
            end
        end else if (d_rsp_data !== 32'h0) begin
            errors++;
            $display("FAIL d_rsp_data idle: got %h, expected 0", d_rsp_data);
        end
    end

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_i(input logic [BW-1:0] data);
        exp_t e;
        e.data = data; e.due = cyc_n + RD_LAT;
        qi.push_back(e);
    endtask

    task automatic push_d(input logic [BW-1:0] data);
        exp_t e;
        e.data = data; e.due = cyc_n + RD_LAT;
        qd.push_back(e);
    endtask

    // One cycle with the current inputs, checking the grant and memory drive
    task automatic step(input string nm, input logic ir, input logic dr, input logic [BW-1:0] addr);
        @(negedge clk);
        chk({nm, " i_ready"}, 32'(i_ready), 32'(ir));
        chk({nm, " d_ready"}, 32'(d_ready), 32'(dr));
        chk({nm, " mem_en"}, 32'(mem_en), 32'(ir | dr));
        chk({nm, " mem_addr"}, mem_addr, addr);
        tick();
    endtask

    task automatic chk_zero(input string nm);
        @(negedge clk);
        chk({nm, " strobes"}, 32'({i_ready, d_ready, mem_en, mem_we, i_rsp_valid, d_rsp_valid}), 32'h0);
        chk({nm, " mem_addr"}, mem_addr, 32'h0);
        chk({nm, " mem_wdata"}, mem_wdata, 32'h0);
        chk({nm, " rsp_data"}, i_rsp_data | d_rsp_data, 32'h0);
    endtask

    task automatic idle();
        i_valid = 1'b0; d_valid = 1'b0; d_wr = 1'b0; i_flush = 1'b0; mem_ready = 1'b1;
        i_addr = '0; d_addr = '0; d_wdata = '0;
    endtask

    initial begin
        logic [5:0] pat;
        idle();
        reset = 1'b1; i_valid = 1'b1; d_valid = 1'b1; i_flush = 1'b1;
        i_addr = 32'h100; d_addr = 32'h40;
        tick(); tick();
        chk_zero("reset");
        tick();
        reset = 1'b0; idle(); tick();

        // Priority with streak limit: D,D,D,D,I,D
        i_valid = 1'b1; i_addr = 32'h100;
        d_valid = 1'b1; d_wr = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234_5678;
        pat = 6'b101111;
        for (int k = 0; k < 6; k++) begin
            if (!pat[k]) push_i(32'h0000_AAAA);
            step("prio", !pat[k], pat[k], pat[k] ? 32'h40 : 32'h100);
        end
        idle(); tick(); tick(); tick();

        // Read latency and routing
        i_valid = 1'b1; i_addr = 32'h100; push_i(32'h0000_AAAA);
        step("lat_i", 1'b1, 1'b0, 32'h100);
        i_valid = 1'b0; d_valid = 1'b1; d_wr = 1'b0; d_addr = 32'h200; push_d(32'h0000_BBBB);
        step("lat_d", 1'b0, 1'b1, 32'h200);
        idle(); tick(); tick(); tick();

        // Store, then read it back
        d_valid = 1'b1; d_wr = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("store en/we/ready", 32'({mem_en, mem_we, d_ready}), 32'h7);
        chk("store mem_addr", mem_addr, 32'h40);
        chk("store mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        d_wr = 1'b0; push_d(32'hDEAD_BEEF);
        step("store_rd", 1'b0, 1'b1, 32'h40);
        idle(); tick(); tick(); tick(); tick();

        // Flush of in-flight and same-cycle fetches
        i_valid = 1'b1; i_addr = 32'h100;
        @(negedge clk);
        chk("fetch mem_wdata", mem_wdata, 32'h0);
        tick();
        i_addr = 32'h104; step("fl1", 1'b1, 1'b0, 32'h104);
        i_valid = 1'b0; d_valid = 1'b1; d_wr = 1'b0; d_addr = 32'h200; i_flush = 1'b1;
        push_d(32'h0000_BBBB);
        step("fl2", 1'b0, 1'b1, 32'h200);
        d_valid = 1'b0; i_valid = 1'b1; i_addr = 32'h108; i_flush = 1'b1;
        step("fl3", 1'b1, 1'b0, 32'h108);
        i_flush = 1'b0; i_addr = 32'h100; push_i(32'h0000_AAAA);
        step("fl4", 1'b1, 1'b0, 32'h100);
        idle(); tick(); tick(); tick();

        // Backpressure freezes the streak
        i_valid = 1'b1; i_addr = 32'h100;
        d_valid = 1'b1; d_wr = 1'b1; d_addr = 32'h44; d_wdata = 32'h5555;
        step("bp_pre0", 1'b0, 1'b1, 32'h44);
        step("bp_pre1", 1'b0, 1'b1, 32'h44);
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) step("bp_stall", 1'b0, 1'b0, 32'h0);
        mem_ready = 1'b1;
        step("bp_post0", 1'b0, 1'b1, 32'h44);
        step("bp_post1", 1'b0, 1'b1, 32'h44);
        push_i(32'h0000_AAAA);
        step("bp_post2", 1'b1, 1'b0, 32'h100);
        idle(); tick(); tick(); tick();

        // Reset drops an in-flight read
        i_valid = 1'b1; i_addr = 32'h100;
        step("rst_rd", 1'b1, 1'b0, 32'h100);
        reset = 1'b1; i_flush = 1'b1; d_valid = 1'b1; d_addr = 32'h200;
        chk_zero("mid_reset");
        tick();
        reset = 1'b0; idle();
        tick(); tick(); tick(); tick();

        chk("i queue drained", 32'(qi.size()), 32'h0);
        chk("d queue drained", 32'(qd.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between the core's instruction-fetch requester (I) and its load/store requester (D).
- Issues at most one memory access per cycle. Reads have a fixed latency, and read data is routed back to the requester that issued the read, in order.
- D has priority, bounded by an anti-starvation limit so that fetch always makes progress.
- Sits between the pipelined core's fetch/load-store ports and the memory macro.

Parameters:
- BUS_WIDTH, 32: address and data width.
- RD_LAT, 2: memory read latency in cycles, from the mem_en/read cycle to the mem_rdata-valid cycle; legal range is 1 or more.
- MAX_D_STREAK, 4: maximum consecutive D grants while I is waiting; legal range is 1 to 15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- i_valid  in  1  fetch request.
- i_ready  out  1  fetch request accepted this cycle.
- i_addr  in  BUS_WIDTH  fetch address.
- i_flush  in  1  squash all in-flight fetch reads (branch taken).
- i_rsp_valid  out  1  fetch read data valid.
- i_rsp_data  out  BUS_WIDTH  fetch read data.
- d_valid  in  1  data request.
- d_ready  out  1  data request accepted this cycle.
- d_wr  in  1  1 = store, 0 = load.
- d_addr  in  BUS_WIDTH  data address.
- d_wdata  in  BUS_WIDTH  store data.
- d_rsp_valid  out  1  load data valid.
- d_rsp_data  out  BUS_WIDTH  load data.
- mem_ready  in  1  memory can accept an access this cycle.
- mem_en  out  1  access strobe.
- mem_we  out  1  write strobe.
- mem_addr  out  BUS_WIDTH  access address.
- mem_wdata  out  BUS_WIDTH  write data.
- mem_rdata  in  BUS_WIDTH  read data, valid RD_LAT cycles after a read strobe.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset clears the tag pipeline and sets streak_cnt to 0.
- While reset is high, all outputs are 0: i_ready, d_ready, mem_en, mem_we, i_rsp_valid, d_rsp_valid; mem_addr, mem_wdata and both rsp_data outputs are driven 0.
- Reset mid-operation drops every in-flight read; no response is produced for it.
- Grant is combinational, evaluated every cycle:
  - mem_ready=0: no grant.
  - Otherwise, if d_valid and (!i_valid or streak_cnt < MAX_D_STREAK): grant D.
  - Otherwise, if i_valid: grant I.
- i_ready = grant_I and d_ready = grant_D; they are never both 1.
- A request is transferred when valid and ready are both 1. Requesters hold valid, address and data stable until accepted.
- Memory drive:
  - mem_en = grant_I | grant_D.
  - mem_we = grant_D & d_wr.
  - mem_addr, mem_wdata are muxed from the granted requester.
  - mem_wdata is 0 for I grants.
  - With no grant, mem_addr and mem_wdata are 0.
- streak_cnt (4-bit) is registered:
  - Cleared when I is granted or when i_valid=0.
  - Incremented on a D grant while i_valid=1.
  - Saturates at MAX_D_STREAK.
  - A mem_ready=0 cycle leaves it unchanged.
- Tag pipeline is a shift register of depth RD_LAT; each entry holds {vld, id}, where id 0 = I and 1 = D.
  - Stage 0 loads vld = a read was granted this cycle (I grant, or D grant with d_wr=0), and id = the granted requester.
  - Stores never enter the pipeline and produce no response.
  - The pipeline shifts every cycle, independent of mem_ready.
- Response, taken from the pipeline's last stage:
  - If vld and id=I: i_rsp_valid=1 for one cycle.
  - If vld and id=D: d_rsp_valid=1 for one cycle.
  - rsp_data = mem_rdata when its rsp_valid=1, else 0.
  - Responses have no backpressure and are delivered in issue order.
- i_flush=1 clears vld on every in-flight I entry, including an I read being granted in the same cycle.
  - The response at the last stage in that cycle is also suppressed: i_rsp_valid=0.
  - D entries are unaffected.
  - i_flush does not block a new I grant in the following cycle.
- Simultaneous events:
  - A D grant and a last-stage I response in the same cycle are independent; both proceed.
  - i_flush together with reset: reset wins, with the same outcome.

Test Plan:
- Priority and streak limit: after reset, i_valid=1 and d_valid=1 held for 6 cycles with MAX_D_STREAK=4, mem_ready=1 → grants D,D,D,D,I,D; streak_cnt returns to 0 after the I grant.
- Read latency and routing: I read of 0x100 in cycle 0, D load of 0x200 in cycle 1, RD_LAT=2, memory returns 0xAAAA then 0xBBBB → i_rsp_valid=1 with 0xAAAA in cycle 2; d_rsp_valid=1 with 0xBBBB in cycle 3.
- Store: D store of 0xDEADBEEF to 0x40 → mem_en=1, mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF in the same cycle; no d_rsp_valid at any later cycle.
- Flush: I reads granted at cycles 0 and 1, D load at cycle 2, i_flush=1 at cycle 2 → no i_rsp_valid in cycles 2–4; d_rsp_valid=1 in cycle 4.
- Backpressure: mem_ready=0 for 3 cycles with both requesters valid → i_ready=d_ready=mem_en=0 and streak_cnt unchanged; grants resume the cycle mem_ready=1.
- Reset mid-flight: I read granted, then reset asserted one cycle later for one cycle → no i_rsp_valid; all outputs are 0 during reset.
